diff_sub: RTL and testbench
===========================

// Module: diff_sub
// PURPOSE
//  Registered N-bit unsigned subtractor with borrow chain: d = x - y - b_in, plus borrow-out.
//  b_out=1 iff x < y + b_in (unsigned), so b_out doubles as a "less-than" flag.
//  Minimum-selection datapaths (e.g. the 3-sample min of the A/D acquisition unit) use b_out to drive their muxes.
//  Cascadable: b_out of a low slice feeds b_in of a high slice.
// PARAMETERS
//  N  8  operand/result width in bits (N >= 1)
// PORTS
//  clock      in   1  system clock, all state updates on rising edge
//  reset      in   1  asynchronous reset, active-high
//  in_valid   in   1  x, y, b_in are valid this cycle
//  x          in   N  minuend, unsigned
//  y          in   N  subtrahend, unsigned
//  b_in       in   1  borrow in (1 = subtract one more)
//  out_valid  out  1  d, b_out, zero hold the result of an accepted operation
//  d          out  N  difference, mod 2^N (see CONFIGURATION)
//  b_out      out  1  borrow out of MSB cell
//  zero       out  1  1 iff d == 0
// BEHAVIOUR
//  - Reset (asynchronous, any time): out_valid=0, d=0, b_out=0, zero=1; applies immediately, not at next edge.
//  - The datapath is a ripple-borrow chain of N 1-bit full-subtractor cells:
//    d_i = x_i ^ y_i ^ bw_i; bw_{i+1} = (~x_i & y_i) | (~(x_i ^ y_i) & bw_i); bw_0 = b_in; b_out = bw_N.
//  - Latency: one cycle. Rising edge with in_valid=1 registers d, b_out, zero; out_valid=1 the following cycle.
//  - Edge with in_valid=0: out_valid<=0; d, b_out, zero hold their last values.
//  - Back-to-back in_valid gives one result per cycle; there is no stall or backpressure.
//  - Wrap-around: x=0, y=2^N-1, b_in=1 -> d=0, b_out=1 (result mod 2^N).
//  - Equal operands: x==y, b_in=0 -> d=0, b_out=0, zero=1. With b_in=1 -> d=2^N-1, b_out=1.
//  - Reset deasserted mid-stream: the first valid edge after release produces a normal result; no stale data is output.
//  - X/unknown inputs are not required to be handled.
// CONFIGURATION
//  Macro DIFF_SUB_SAT_EN:
//  - Defined: unsigned saturating mode. When b_out=1, d is forced to 0 and zero=1; b_out still reports 1.
//  - Undefined: d is the plain wrap-around difference mod 2^N.
// TESTING  (N=8)
//  1. Assert reset mid-operation with out_valid=1 -> out_valid=0, d=0, b_out=0, zero=1 without waiting for a clock edge.
//  2. x=200, y=55, b_in=0, in_valid=1 for 1 cycle -> next cycle out_valid=1, d=145, b_out=0, zero=0; then out_valid=0 with d held.
//  3. x=10, y=20, b_in=0 -> b_out=1, d=246 (wrap); with DIFF_SUB_SAT_EN defined, d=0, zero=1.
//  4. x=77, y=77: b_in=0 -> d=0, zero=1, b_out=0; b_in=1 -> d=255, b_out=1.
//  5. Back-to-back: (0,255,1), (255,0,0), (128,127,0) on consecutive cycles -> d=0/b=1, 255/0, 1/0 on consecutive cycles.
//  6. Random sweep, 10k vectors -> {b_out,d} == {1'b0,x} - y - b_in every accepted cycle.

Source files
------------

// File: rtl/diff_sub.sv
// Registered N-bit unsigned subtractor with ripple borrow chain: d = x - y - b_in, plus borrow-out.
// Optional macro DIFF_SUB_SAT_EN clamps the difference to 0 whenever a borrow leaves the MSB.
module diff_sub #(
  parameter int N = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         b_in,
  output logic         out_valid,
  output logic [N-1:0] d,
  output logic         b_out,
  output logic         zero
);

  // Chain of 1-bit full-subtractor cells; returns {borrow out of MSB, difference}.
  function automatic logic [N:0] ripple_sub(input logic [N-1:0] a,
                                            input logic [N-1:0] b,
                                            input logic         bin);
    logic         bw;
    logic [N-1:0] diff;
    bw   = bin;
    diff = '0;
    for (int i = 0; i < N; i++) begin
      diff[i] = a[i] ^ b[i] ^ bw;
      bw      = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & bw);
    end
    return {bw, diff};
  endfunction

`ifdef DIFF_SUB_SAT_EN
  // A borrow out means the true result went negative; floor it at zero.
  function automatic logic [N-1:0] sat_floor(input logic [N-1:0] diff,
                                             input logic         borrow);
    return borrow ? '0 : diff;
  endfunction
`endif

  logic [N:0]   sub_raw;
  logic [N-1:0] d_nxt;
  logic         b_nxt;

  logic         vld_p0;
  logic [N-1:0] d_p0;
  logic         b_p0;
  logic         zero_p0;

  assign sub_raw = ripple_sub(x, y, b_in);
  assign b_nxt   = sub_raw[N];
`ifdef DIFF_SUB_SAT_EN
  assign d_nxt   = sat_floor(sub_raw[N-1:0], b_nxt);
`else
  assign d_nxt   = sub_raw[N-1:0];
`endif

  // Stage p0: result register; data holds its value on idle cycles.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_p0  <= 1'b0;
      d_p0    <= '0;
      b_p0    <= 1'b0;
      zero_p0 <= 1'b1;
    end else begin
      vld_p0 <= in_valid;
      if (in_valid) begin
        d_p0    <= d_nxt;
        b_p0    <= b_nxt;
        zero_p0 <= (d_nxt == '0);
      end
    end
  end

  assign out_valid = vld_p0;
  assign d         = d_p0;
  assign b_out     = b_p0;
  assign zero      = zero_p0;

endmodule

// File: tb/tb_diff_sub.sv
// Directed and random checks for diff_sub (N=8); honours DIFF_SUB_SAT_EN in its expectations.
module tb_diff_sub;

  logic       clock;
  logic       reset;
  logic       in_valid;
  logic [7:0] x;
  logic [7:0] y;
  logic       b_in;
  logic       out_valid;
  logic [7:0] d;
  logic       b_out;
  logic       zero;

  int n_total = 0;
  int n_pass  = 0;

  diff_sub #(.N(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .x         (x),
    .y         (y),
    .b_in      (b_in),
    .out_valid (out_valid),
    .d         (d),
    .b_out     (b_out),
    .zero      (zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       v;
    logic [7:0] x;
    logic [7:0] y;
    logic       b;
    logic [7:0] ed;  // wrap-around difference expected (or held value when v=0)
    logic       eb;
  } vec_t;

  function automatic logic [7:0] exp_d(input logic [7:0] dd, input logic bb);
`ifdef DIFF_SUB_SAT_EN
    return bb ? 8'd0 : dd;
`else
    return dd;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  task automatic drive(input logic v, input logic [7:0] xx, input logic [7:0] yy, input logic bb);
    in_valid = v;
    x        = xx;
    y        = yy;
    b_in     = bb;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [7:0] ed, input logic eb);
    logic [7:0] dd;
    dd = exp_d(ed, eb);
    check({tag, ".out_valid"}, out_valid, v);
    check({tag, ".d"}, d, dd);
    check({tag, ".b_out"}, b_out, eb);
    check({tag, ".zero"}, zero, dd == 8'd0);
  endtask

  vec_t vecs[10];

  initial begin
    logic [8:0] full;
    logic [7:0] hold_d;
    logic       hold_b;
    logic       pend_v;

    vecs[0] = '{1'b1,  8'd10,  8'd20, 1'b0, 8'd246, 1'b1};
    vecs[1] = '{1'b1,  8'd77,  8'd77, 1'b0, 8'd0,   1'b0};
    vecs[2] = '{1'b1,  8'd77,  8'd77, 1'b1, 8'd255, 1'b1};
    vecs[3] = '{1'b1,  8'd0,   8'd255, 1'b1, 8'd0,  1'b1};
    vecs[4] = '{1'b1,  8'd255, 8'd0,  1'b0, 8'd255, 1'b0};
    vecs[5] = '{1'b1,  8'd128, 8'd127, 1'b0, 8'd1,  1'b0};
    vecs[6] = '{1'b0,  8'd9,   8'd1,  1'b0, 8'd1,   1'b0};
    vecs[7] = '{1'b1,  8'd0,   8'd0,  1'b1, 8'd255, 1'b1};
    vecs[8] = '{1'b1,  8'd5,   8'd3,  1'b1, 8'd1,   1'b0};
    vecs[9] = '{1'b1,  8'd200, 8'd199, 1'b1, 8'd0,  1'b0};

    reset = 1'b1;
    drive(1'b0, 8'd0, 8'd0, 1'b0);
    #2;
    check_out("reset", 1'b0, 8'd0, 1'b0);

    @(negedge clock);
    reset = 1'b0;
    drive(1'b1, 8'd200, 8'd55, 1'b0);
    @(negedge clock);
    check_out("single", 1'b1, 8'd145, 1'b0);
    drive(1'b0, 8'd1, 8'd2, 1'b1);
    @(negedge clock);
    check_out("idle_hold", 1'b0, 8'd145, 1'b0);

    // Consecutive entries are applied back-to-back, one per cycle.
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].v, vecs[i].x, vecs[i].y, vecs[i].b);
      @(negedge clock);
      check_out($sformatf("vec%0d", i), vecs[i].v, vecs[i].ed, vecs[i].eb);
    end

    // Asynchronous reset while a result is being presented.
    drive(1'b1, 8'd10, 8'd20, 1'b0);
    @(negedge clock);
    check_out("pre_reset", 1'b1, 8'd246, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check_out("async_reset", 1'b0, 8'd0, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    drive(1'b1, 8'd3, 8'd1, 1'b0);
    @(negedge clock);
    check_out("after_reset", 1'b1, 8'd2, 1'b0);

    // Random sweep against the arithmetic definition.
    hold_d = 8'd2;
    hold_b = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      logic       rv;
      logic [7:0] rx;
      logic [7:0] ry;
      logic       rb;
      rv = ($urandom_range(0, 9) != 0);
      rx = 8'($urandom_range(0, 255));
      ry = 8'($urandom_range(0, 255));
      rb = 1'($urandom_range(0, 1));
      drive(rv, rx, ry, rb);
      full   = {1'b0, rx} - {1'b0, ry} - {8'd0, rb};
      pend_v = rv;
      if (rv) begin
        hold_d = full[7:0];
        hold_b = full[8];
      end
      @(negedge clock);
      check("rand.out_valid", out_valid, pend_v);
      check("rand.bd", {b_out, d}, {hold_b, exp_d(hold_d, hold_b)});
    end

    drive(1'b0, 8'd0, 8'd0, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
